// File: rtl/flash_arbiter_pkg.sv
// Shared encodings for the flash read-port arbiter: FSM states, grant IDs, widths.
package flash_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic GRANT_FETCH = 1'b0;
    localparam logic GRANT_DATA  = 1'b1;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 8;
    localparam int TMO_W  = 20;

endpackage

// File: rtl/flash_arbiter_rr.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to the
// requester that was not served last.
module rr_arbiter_2
    import flash_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       valid_o,
    output logic       grant_o
);

    always_comb begin
        valid_o = |req_i;
        grant_o = GRANT_FETCH;
        case (req_i)
            2'b01:   grant_o = GRANT_FETCH;
            2'b10:   grant_o = GRANT_DATA;
            2'b11:   grant_o = ~last_grant_i;
            default: grant_o = GRANT_FETCH;
        endcase
    end

endmodule

// File: rtl/flash_arbiter.sv
// Shares the flash_rom read port between CPU fetch and data-load paths,
// one byte per grant, sequenced through the ROM's hit/miss busy timing.
module flash_arbiter
    import flash_arbiter_pkg::*;
#(
    parameter logic [TMO_W-1:0]  TIMEOUT_CYCLES = 20'hfffff,
    parameter logic [DATA_W-1:0] TIMEOUT_DATA   = 8'hff
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_address,
    output logic              fetch_ack,
    output logic [DATA_W-1:0] fetch_data,
    input  logic              data_req,
    input  logic [ADDR_W-1:0] data_address,
    output logic              data_ack,
    output logic [DATA_W-1:0] data_data,
    output logic [ADDR_W-1:0] rom_address,
    output logic              rom_enable,
    input  logic              rom_busy,
    input  logic [DATA_W-1:0] rom_data,
    output logic              timeout_error
);

    localparam logic [TMO_W-1:0] TMO_LAST = TIMEOUT_CYCLES - TMO_W'(1);

    state_e             state_q;
    logic               grant_q;
    logic               last_grant_q;
    logic [TMO_W-1:0]   tmo_cnt_q;
    logic [TMO_W-1:0]   tmo_cnt_d;
    logic [ADDR_W-1:0]  rom_address_q;
    logic               rom_enable_q;
    logic               fetch_ack_q;
    logic [DATA_W-1:0]  fetch_data_q;
    logic               data_ack_q;
    logic [DATA_W-1:0]  data_data_q;
    logic               timeout_error_q;

    logic               arb_valid;
    logic               arb_grant;
    logic               tmo_hit;
    logic [DATA_W-1:0]  ret_byte;

    rr_arbiter_2 u_rr (
        .req_i        ({data_req, fetch_req}),
        .last_grant_i (last_grant_q),
        .valid_o      (arb_valid),
        .grant_o      (arb_grant)
    );

    // Counter saturates rather than wrapping so a huge TIMEOUT_CYCLES can't alias.
    assign tmo_cnt_d = (&tmo_cnt_q) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);
    assign tmo_hit   = (tmo_cnt_q == TMO_LAST);
    assign ret_byte  = rom_busy ? TIMEOUT_DATA : rom_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            grant_q         <= GRANT_FETCH;
            last_grant_q    <= GRANT_DATA;
            tmo_cnt_q       <= '0;
            rom_address_q   <= '0;
            rom_enable_q    <= 1'b0;
            fetch_ack_q     <= 1'b0;
            fetch_data_q    <= '0;
            data_ack_q      <= 1'b0;
            data_data_q     <= '0;
            timeout_error_q <= 1'b0;
        end else begin
            fetch_ack_q <= 1'b0;
            data_ack_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_valid) begin
                        grant_q       <= arb_grant;
                        rom_address_q <= (arb_grant == GRANT_DATA) ? data_address : fetch_address;
                        rom_enable_q  <= 1'b1;
                        tmo_cnt_q     <= '0;
                        state_q       <= ST_ISSUE;
                    end
                end
                // Busy is not yet meaningful the cycle after the address is issued.
                ST_ISSUE: state_q <= ST_WAIT;
                ST_WAIT: begin
                    if (!rom_busy || tmo_hit) begin
                        if (grant_q == GRANT_DATA) begin
                            data_data_q <= ret_byte;
                            data_ack_q  <= 1'b1;
                        end else begin
                            fetch_data_q <= ret_byte;
                            fetch_ack_q  <= 1'b1;
                        end
                        if (rom_busy) timeout_error_q <= 1'b1;
                        // A timed-out read still counts as service for fairness.
                        last_grant_q <= grant_q;
                        state_q      <= ST_DONE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_d;
                    end
                end
                ST_DONE: begin
                    rom_enable_q <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign fetch_ack     = fetch_ack_q;
    assign fetch_data    = fetch_data_q;
    assign data_ack      = data_ack_q;
    assign data_data     = data_data_q;
    assign rom_address   = rom_address_q;
    assign rom_enable    = rom_enable_q;
    assign timeout_error = timeout_error_q;

endmodule

// File: tb/tb_flash_arbiter.sv
// Scoreboard bench for flash_arbiter with a behavioural flash_rom (page hit/miss).
module tb_flash_arbiter;

    localparam logic [19:0] TMO = 20'd400;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_req = 1'b0;
    logic [23:0] fetch_address = '0;
    logic        fetch_ack;
    logic [7:0]  fetch_data;
    logic        data_req = 1'b0;
    logic [23:0] data_address = '0;
    logic        data_ack;
    logic [7:0]  data_data;
    logic [23:0] rom_address;
    logic        rom_enable;
    logic        rom_busy;
    logic [7:0]  rom_data;
    logic        timeout_error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    flash_arbiter #(.TIMEOUT_CYCLES(TMO), .TIMEOUT_DATA(8'hff)) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_address(fetch_address),
        .fetch_ack(fetch_ack), .fetch_data(fetch_data),
        .data_req(data_req), .data_address(data_address),
        .data_ack(data_ack), .data_data(data_data),
        .rom_address(rom_address), .rom_enable(rom_enable),
        .rom_busy(rom_busy), .rom_data(rom_data),
        .timeout_error(timeout_error)
    );

    function automatic logic [7:0] mem(input logic [23:0] a);
        if (a == 24'h000123) return 8'h5a;
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3c;
    endfunction

    // flash_rom model: one loaded page; miss = busy for miss_len cycles (0 = random 1..5)
    logic        stuck = 1'b0;
    int          miss_len = 2;
    logic [15:0] pg_q;
    logic [23:0] pend_q;
    int          cnt_q;

    always @(posedge clk) begin
        if (reset) begin
            rom_busy <= 1'b0;
            rom_data <= '0;
            pg_q     <= 16'h0001;
            pend_q   <= '0;
            cnt_q    <= 0;
        end else if (stuck) begin
            rom_busy <= 1'b1;
        end else if (cnt_q > 0) begin
            if (cnt_q == 1) begin
                rom_busy <= 1'b0;
                rom_data <= mem(pend_q);
                pg_q     <= pend_q[23:8];
            end
            cnt_q <= cnt_q - 1;
        end else if (rom_enable) begin
            if (rom_address[23:8] == pg_q) begin
                rom_busy <= 1'b0;
                rom_data <= mem(rom_address);
            end else begin
                rom_busy <= 1'b1;
                pend_q   <= rom_address;
                cnt_q    <= (miss_len > 0) ? miss_len : int'($urandom_range(1, 5));
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard state
    logic [7:0] q_f[$];
    logic [7:0] q_d[$];
    bit         ack_log[$];
    logic [7:0] last_f, last_d;
    bit         pend_f, pend_d, have_last, last_port;
    int         since_f, since_d, last_ack_cyc;
    int         cyc = 0;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (reset) begin
            last_f = '0; last_d = '0;
            pend_f = 0; pend_d = 0; have_last = 0;
            q_f.delete(); q_d.delete();
        end else begin
            if (fetch_req && !pend_f) begin pend_f = 1; since_f = cyc; end
            if (data_req && !pend_d) begin pend_d = 1; since_d = cyc; end
            if (fetch_ack || data_ack) chk("ack_exclusive", {fetch_ack, data_ack} == 2'b11, 0);
            if (fetch_ack) begin
                if (q_f.size() == 0) chk("fetch_ack_unexpected", 1, 0);
                else begin last_f = q_f.pop_front(); chk("fetch_data", fetch_data, last_f); end
                if (have_last && pend_d && since_d <= last_ack_cyc) chk("rr_fetch_prev", last_port, 1);
                ack_log.push_back(0);
                have_last = 1; last_port = 0; last_ack_cyc = cyc; pend_f = 0;
            end else chk("fetch_data_hold", fetch_data, last_f);
            if (data_ack) begin
                if (q_d.size() == 0) chk("data_ack_unexpected", 1, 0);
                else begin last_d = q_d.pop_front(); chk("data_data", data_data, last_d); end
                if (have_last && pend_f && since_f <= last_ack_cyc) chk("rr_data_prev", last_port, 0);
                ack_log.push_back(1);
                have_last = 1; last_port = 1; last_ack_cyc = cyc; pend_d = 0;
            end else chk("data_data_hold", data_data, last_d);
        end
    end

    task automatic drive(input bit p, input bit r, input logic [23:0] a);
        if (p) begin data_req = r; data_address = a; end
        else begin fetch_req = r; fetch_address = a; end
    endtask

    task automatic push(input bit p, input logic [23:0] a);
        logic [7:0] e;
        e = stuck ? 8'hff : mem(a);
        if (p) q_d.push_back(e); else q_f.push_back(e);
    endtask

    function automatic bit ack_of(input bit p);
        return p ? data_ack : fetch_ack;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; fetch_req = 1'b0; data_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // One request; lat = clock edges from req rising to ack visible.
    task automatic req_one(input bit p, input logic [23:0] a, input int maxc, input bit swap,
                           output int lat, output bit hold_ok);
        bit got;
        got = 0; lat = 0; hold_ok = 1;
        @(posedge clk); #1;
        drive(p, 1, a); push(p, a);
        @(negedge clk);
        while (!got && lat < maxc) begin
            @(negedge clk); lat++;
            if (rom_busy && !(rom_enable && rom_address == a)) hold_ok = 0;
            if (swap && lat == 5) drive(p, 1, ~a);
            got = ack_of(p);
        end
        if (!got) chk("req_one_ack_timeout", 0, 1);
        @(posedge clk); #1;
        drive(p, 0, a);
    endtask

    task automatic run_port(input bit p, input int n, input bit rnd);
        logic [23:0] a;
        int w;
        bit got;
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            if (rnd) a = {8'h00, 8'($urandom_range(1, 3)), 8'($urandom)};
            else     a = {8'h00, 8'h10 + 8'(p), 8'(i)};
            drive(p, 1, a); push(p, a);
            got = 0; w = 0;
            while (!got && w < 200) begin @(negedge clk); w++; got = ack_of(p); end
            if (!got) chk("port_ack_timeout", 0, 1);
            @(posedge clk); #1;
            if (rnd && $urandom_range(0, 1) == 1) begin
                drive(p, 0, a);
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
        end
        drive(p, 0, a);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit hold_ok;
        logic [5:0] order;

        do_reset();
        @(negedge clk);
        chk("reset_state", {fetch_ack, data_ack, fetch_data, data_data, rom_address, rom_enable, timeout_error}, 0);

        // Single fetch hit
        req_one(0, 24'h000123, 20, 0, lat, hold_ok);
        chk("t1_latency", lat, 3);
        chk("t1_fetch_data", fetch_data, 8'h5a);

        // Tie from reset goes to fetch, then strict alternation
        do_reset();
        miss_len = 2;
        ack_log.delete();
        fork
            run_port(0, 3, 0);
            run_port(1, 3, 0);
        join
        order = '0;
        for (int i = 0; i < 6 && i < ack_log.size(); i++) order[i] = ack_log[i];
        chk("t2_ack_count", ack_log.size(), 6);
        chk("t2_order", order, 6'b101010);

        // Long page miss
        do_reset();
        miss_len = 300;
        req_one(1, 24'h770042, 400, 0, lat, hold_ok);
        chk("t3_latency", lat, 303);
        chk("t3_addr_held", hold_ok, 1);

        // Busy stuck -> timeout byte, sticky error
        stuck = 1'b1;
        req_one(0, 24'h000200, 500, 0, lat, hold_ok);
        stuck = 1'b0;
        chk("t4_latency", lat, int'(TMO) + 2);
        chk("t4_timeout_error", timeout_error, 1);
        miss_len = 3;
        req_one(1, 24'h000150, 50, 0, lat, hold_ok);
        chk("t4_sticky", timeout_error, 1);

        // Reset in the middle of a WAIT
        miss_len = 50;
        @(posedge clk); #1;
        drive(1, 1, 24'h345678);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1; drive(1, 0, 24'h345678);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t5_reset_outputs", {fetch_ack, data_ack, fetch_data, data_data, rom_address, rom_enable, timeout_error}, 0);
        req_one(0, 24'h000130, 20, 0, lat, hold_ok);
        chk("t5_latency_after_reset", lat, 3);

        // Address changes during WAIT are ignored
        miss_len = 20;
        req_one(0, 24'h000555, 100, 1, lat, hold_ok);
        chk("t6_addr_held", hold_ok, 1);
        chk("t6_latency", lat, 23);

        // Random contention with hit/miss mix
        do_reset();
        miss_len = 0;
        fork
            run_port(0, 30, 1);
            run_port(1, 30, 1);
        join
        repeat (4) @(negedge clk);
        chk("final_fetch_queue_empty", q_f.size(), 0);
        chk("final_data_queue_empty", q_d.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
